// File: rtl/bus_xfer_pkg.sv
// rtl/bus_xfer_pkg.sv - shared types and codes for the bus transfer controller
package bus_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } xfer_state_e;

    localparam logic [1:0] SRC_A   = 2'd0;
    localparam logic [1:0] SRC_B   = 2'd1;
    localparam logic [1:0] SRC_C   = 2'd2;
    localparam logic [1:0] SRC_IMM = 2'd3;

    localparam int DST_A_BIT = 0;
    localparam int DST_B_BIT = 1;
    localparam int DST_C_BIT = 2;

    typedef struct packed {
        logic [1:0] src;
        logic [2:0] dst;
        logic [7:0] imm;
    } xfer_req_t;

    localparam int REQ_W = 13;

    // Picks the value that will be driven onto the bus for a given source code.
    function automatic logic [7:0] select_source(
        input logic [1:0] src,
        input logic [7:0] a_val,
        input logic [7:0] b_val,
        input logic [7:0] c_val,
        input logic [7:0] imm_val
    );
        case (src)
            SRC_A:   return a_val;
            SRC_B:   return b_val;
            SRC_C:   return c_val;
            default: return imm_val;
        endcase
    endfunction

endpackage

// File: rtl/bus_req_fifo.sv
// rtl/bus_req_fifo.sv - request queue with wrapping pointers and element count
module bus_req_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointer and count bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Queue control state, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while the count says empty, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// rtl/bus_transfer_ctrl.sv - queued register-to-register bus transfer sequencer
module bus_transfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_src,
    input  logic [2:0] req_dst,
    input  logic [7:0] req_imm,
    input  logic [7:0] A_in,
    input  logic [7:0] B_in,
    input  logic [7:0] C_in,
    output logic [7:0] Data_bus,
    output logic       bus_oe,
    output logic       A_EN,
    output logic       B_EN,
    output logic       C_EN,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    xfer_state_e state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [2:0]  dst_q, dst_d;
    logic [3:0]  settle_q, settle_d;
    logic        err_q, err_d;
    logic        pop;
    logic        fifo_full, fifo_empty;
    xfer_req_t   head;

    bus_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (req_valid),
        .push_data_i ({req_src, req_dst, req_imm}),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign req_ready = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign err       = err_q;

    // State and transfer datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            hold_q   <= 8'h00;
            dst_q    <= 3'b000;
            settle_q <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            dst_q    <= dst_d;
            settle_q <= settle_d;
            err_q    <= err_d;
        end
    end

    // Next state: pop in IDLE, capture source on the pop edge, time the settle window.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        dst_d    = dst_q;
        settle_d = settle_q;
        err_d    = 1'b0;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.dst != 3'b000) begin
                        state_d  = ST_DRIVE;
                        hold_d   = select_source(head.src, A_in, B_in, C_in, head.imm);
                        dst_d    = head.dst;
                        settle_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_LOAD;
                    settle_d = 4'd0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_LOAD:    state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only, so reset removes enables without waiting for a clock.
    always_comb begin
        bus_oe   = 1'b0;
        Data_bus = 8'h00;
        A_EN     = 1'b0;
        B_EN     = 1'b0;
        C_EN     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_DRIVE: begin
                bus_oe   = 1'b1;
                Data_bus = hold_q;
            end
            ST_LOAD: begin
                bus_oe   = 1'b1;
                Data_bus = hold_q;
                A_EN     = dst_q[DST_A_BIT];
                B_EN     = dst_q[DST_B_BIT];
                C_EN     = dst_q[DST_C_BIT];
            end
            ST_RELEASE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// tb/tb_bus_transfer_ctrl.sv - directed self-checking bench for bus_transfer_ctrl
module tb_bus_transfer_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_valid2 = 1'b0;
    logic [1:0] req_src = 2'd0;
    logic [2:0] req_dst = 3'd0;
    logic [7:0] req_imm = 8'h00;
    logic [7:0] A_in = 8'h00;
    logic [7:0] B_in = 8'h00;
    logic [7:0] C_in = 8'h00;

    logic       req_ready, bus_oe, A_EN, B_EN, C_EN, busy, done, err;
    logic [7:0] Data_bus;
    logic       s_req_ready, s_bus_oe, s_A_EN, s_B_EN, s_C_EN, s_busy, s_done, s_err;
    logic [7:0] s_Data_bus;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    bus_transfer_ctrl #(.SETTLE_CYCLES(1), .FIFO_DEPTH(2)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm),
        .A_in(A_in), .B_in(B_in), .C_in(C_in), .Data_bus(Data_bus), .bus_oe(bus_oe),
        .A_EN(A_EN), .B_EN(B_EN), .C_EN(C_EN), .busy(busy), .done(done), .err(err)
    );

    bus_transfer_ctrl #(.SETTLE_CYCLES(3), .FIFO_DEPTH(2)) dut_s3 (
        .clock(clock), .reset(reset), .req_valid(req_valid2), .req_ready(s_req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm),
        .A_in(A_in), .B_in(B_in), .C_in(C_in), .Data_bus(s_Data_bus), .bus_oe(s_bus_oe),
        .A_EN(s_A_EN), .B_EN(s_B_EN), .C_EN(s_C_EN), .busy(s_busy), .done(s_done), .err(s_err)
    );

    wire [2:0] ens   = {C_EN, B_EN, A_EN};
    wire [2:0] s_ens = {s_C_EN, s_B_EN, s_A_EN};

    task automatic push(input logic [1:0] s, input logic [2:0] d, input logic [7:0] im);
        @(negedge clock);
        req_src = s; req_dst = d; req_imm = im; req_valid = 1'b1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL push_ready got %b expected 1", req_ready);
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #10;
        tests_run++;
        if ({req_ready, busy, bus_oe, ens, done, err, Data_bus} !== {1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_outputs got rdy=%b busy=%b oe=%b en=%b done=%b err=%b bus=%h expected rdy=1 rest 0",
                     req_ready, busy, bus_oe, ens, done, err, Data_bus);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        A_in = 8'h5A;
        push(2'd0, 3'b110, 8'h00);
        @(negedge clock);
        tests_run++;
        if (bus_oe !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_queued got oe=%b busy=%b expected oe=0 busy=1", bus_oe, busy);
        end
        @(negedge clock);
        tests_run++;
        if (bus_oe !== 1'b1 || Data_bus !== 8'h5A || ens !== 3'b000) begin
            tests_failed++;
            $display("FAIL basic_drive got oe=%b bus=%h en=%b expected oe=1 bus=5a en=000", bus_oe, Data_bus, ens);
        end
        @(negedge clock);
        tests_run++;
        if (bus_oe !== 1'b1 || Data_bus !== 8'h5A || ens !== 3'b110 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_load got oe=%b bus=%h en=%b done=%b expected oe=1 bus=5a en=110 done=0",
                     bus_oe, Data_bus, ens, done);
        end
        @(negedge clock);
        tests_run++;
        if (done !== 1'b1 || bus_oe !== 1'b0 || Data_bus !== 8'h00 || ens !== 3'b000) begin
            tests_failed++;
            $display("FAIL basic_release got done=%b oe=%b bus=%h en=%b expected done=1 oe=0 bus=00 en=000",
                     done, bus_oe, Data_bus, ens);
        end
        @(negedge clock);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_idle got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int         en_cyc[$];
        logic [7:0] en_dat[$];
        logic       exp_rdy;
        @(negedge clock);
        req_src = 2'd3; req_dst = 3'b001; req_imm = 8'h11; req_valid = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clock);
            if (i <= 6) begin
                exp_rdy = (i <= 2 || i == 6);
                tests_run++;
                if (req_ready !== exp_rdy) begin
                    tests_failed++;
                    $display("FAIL b2b_ready cycle %0d got %b expected %b", i, req_ready, exp_rdy);
                end
            end
            if (A_EN === 1'b1) begin
                en_cyc.push_back(i);
                en_dat.push_back(Data_bus);
            end
            if (i == 1) req_imm = 8'h22;
            if (i == 2) req_imm = 8'h33;
            if (i == 3) req_valid = 1'b0;
        end
        tests_run++;
        if (en_cyc.size() != 3) begin
            tests_failed++;
            $display("FAIL b2b_count got %0d A_EN pulses expected 3", en_cyc.size());
        end else begin
            tests_run++;
            if (en_cyc[0] != 3 || en_cyc[1] != 7 || en_cyc[2] != 11) begin
                tests_failed++;
                $display("FAIL b2b_spacing got cycles %0d %0d %0d expected 3 7 11", en_cyc[0], en_cyc[1], en_cyc[2]);
            end
            tests_run++;
            if (en_dat[0] !== 8'h11 || en_dat[1] !== 8'h22 || en_dat[2] !== 8'h33) begin
                tests_failed++;
                $display("FAIL b2b_data got %h %h %h expected 11 22 33", en_dat[0], en_dat[1], en_dat[2]);
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drained got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_err();
        push(2'd0, 3'b000, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            tests_run++;
            if (err !== (k == 1) || bus_oe !== 1'b0 || ens !== 3'b000 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL err_cycle%0d got err=%b oe=%b en=%b done=%b expected err=%b oe=0 en=000 done=0",
                         k, err, bus_oe, ens, done, (k == 1));
            end
        end
        tests_run++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_drained got busy=%b rdy=%b expected 0 1", busy, req_ready);
        end
    endtask

    task automatic test_sources();
        logic [1:0] t_src[3] = '{2'd0, 2'd2, 2'd3};
        logic [2:0] t_dst[3] = '{3'b001, 3'b100, 3'b011};
        logic [7:0] t_exp[3] = '{8'h3C, 8'hC3, 8'h7E};
        A_in = 8'h3C; C_in = 8'hC3;
        for (int t = 0; t < 3; t++) begin
            push(t_src[t], t_dst[t], 8'h7E);
            @(negedge clock);
            @(negedge clock);
            @(negedge clock);
            tests_run++;
            if (Data_bus !== t_exp[t] || ens !== t_dst[t]) begin
                tests_failed++;
                $display("FAIL src%0d_load got bus=%h en=%b expected bus=%h en=%b", t_src[t], Data_bus, ens, t_exp[t], t_dst[t]);
            end
            @(negedge clock);
            @(negedge clock);
        end
    endtask

    task automatic test_src_change();
        B_in = 8'hAA;
        push(2'd1, 3'b001, 8'h00);
        @(negedge clock);
        @(negedge clock);
        tests_run++;
        if (bus_oe !== 1'b1 || Data_bus !== 8'hAA) begin
            tests_failed++;
            $display("FAIL chg_drive got oe=%b bus=%h expected 1 aa", bus_oe, Data_bus);
        end
        B_in = 8'hBB;
        @(negedge clock);
        tests_run++;
        if (Data_bus !== 8'hAA || ens !== 3'b001) begin
            tests_failed++;
            $display("FAIL chg_load got bus=%h en=%b expected aa 001", Data_bus, ens);
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_settle();
        int   oe_cnt = 0;
        logic exp_oe;
        B_in = 8'h66;
        @(negedge clock);
        req_src = 2'd1; req_dst = 3'b010; req_valid2 = 1'b1;
        tests_run++;
        if (s_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL s3_ready got %b expected 1", s_req_ready);
        end
        @(posedge clock);
        #1 req_valid2 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            exp_oe = (k >= 1 && k <= 4);
            if (s_bus_oe === 1'b1) oe_cnt++;
            tests_run++;
            if (s_bus_oe !== exp_oe || s_Data_bus !== (exp_oe ? 8'h66 : 8'h00) ||
                s_ens !== ((k == 4) ? 3'b010 : 3'b000) || s_done !== (k == 5)) begin
                tests_failed++;
                $display("FAIL s3_cycle%0d got oe=%b bus=%h en=%b done=%b expected oe=%b en=%b done=%b",
                         k, s_bus_oe, s_Data_bus, s_ens, s_done, exp_oe, ((k == 4) ? 3'b010 : 3'b000), (k == 5));
            end
        end
        tests_run++;
        if (oe_cnt != 4) begin
            tests_failed++;
            $display("FAIL s3_oe_len got %0d expected 4", oe_cnt);
        end
    endtask

    task automatic test_reset_load();
        A_in = 8'h99;
        push(2'd0, 3'b001, 8'h00);
        push(2'd0, 3'b010, 8'h00);
        @(negedge clock);
        @(negedge clock);
        tests_run++;
        if (ens !== 3'b001 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_load got en=%b busy=%b expected 001 1", ens, busy);
        end
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if (ens !== 3'b000 || bus_oe !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_async got en=%b oe=%b done=%b busy=%b rdy=%b expected 000 0 0 0 1",
                     ens, bus_oe, done, busy, req_ready);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0 || bus_oe !== 1'b0 || req_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL rst_after%0d got done=%b busy=%b oe=%b rdy=%b expected 0 0 0 1",
                         k, done, busy, bus_oe, req_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_err();
        test_sources();
        test_src_change();
        test_settle();
        test_reset_load();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
